mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of mem_controller.
- Accepts one core memory request at a time on a valid/ready handshake.
- Drives mem_controller's read/write strobes, address and write data, then waits out the fixed memory read latency.
- Returns one response pulse per request, carrying registered read data for loads.

---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_acc_lat_cnt.sv | 27 ++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store sequencer: FSM encoding, counter width,
// and the datapath width taken from DATA_WIDTH (32 when not supplied).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_access_unit_pkg;

    localparam int DATA_W        = `DATA_WIDTH;
    localparam int MEM_ACC_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_acc_lat_cnt.sv
// Read-latency counter: clear/increment with a terminal flag one
// cycle before the configured latency is reached.
module mem_acc_lat_cnt
    import mem_access_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [MEM_ACC_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + MEM_ACC_CNT_W'(1);
        end
    end

    assign term = (cnt == MEM_ACC_CNT_W'(READ_LATENCY - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of mem_controller.
// Optional MEM_ACC_POSTED_WR_EN: stores complete in one cycle from IDLE.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int DW           = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          busy,
    output logic          mc_ren,
    output logic          mc_wen,
    output logic [DW-1:0] mc_address,
    output logic [DW-1:0] mc_wdata,
    input  logic [DW-1:0] mc_rdata
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_term;
    logic   rd_done;
    logic   wr_done;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign rd_done   = (state == RD_WAIT) && cnt_term;

`ifdef MEM_ACC_POSTED_WR_EN
    assign wr_done = accept && req_we;
`else
    assign wr_done = (state == WR_ISSUE);
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !req_we) begin
                    state_nxt = RD_ISSUE;
                end else if (accept) begin
`ifdef MEM_ACC_POSTED_WR_EN
                    state_nxt = IDLE;
`else
                    state_nxt = WR_ISSUE;
`endif
                end
            end
            RD_ISSUE: begin
                state_nxt = RD_WAIT;
                cnt_clr   = 1'b1;
            end
            RD_WAIT: begin
                cnt_inc = 1'b1;
                if (cnt_term) begin
                    state_nxt = IDLE;
                end
            end
            WR_ISSUE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are registered off the accept so they are glitch-free
    // and identical in timing for posted and non-posted stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mc_ren     <= 1'b0;
            mc_wen     <= 1'b0;
            resp_valid <= 1'b0;
            mc_address <= '0;
            mc_wdata   <= '0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            mc_ren     <= accept && !req_we;
            mc_wen     <= accept && req_we;
            resp_valid <= rd_done || wr_done;
            if (accept) begin
                mc_address <= req_addr;
                mc_wdata   <= req_wdata;
            end
            if (rd_done) begin
                resp_rdata <= mc_rdata;
            end
        end
    end

    mem_acc_lat_cnt #(
        .READ_LATENCY(READ_LATENCY)
    ) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .term(cnt_term)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (latency 1 and 4)
// with a delayed-read memory model and a response scoreboard.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int DW = DATA_W;
`ifdef MEM_ACC_POSTED_WR_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = 2;
`endif
    localparam logic [DW-1:0] GARB = DW'(32'hBAD0_BAD0);

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rv      [2];
    logic          rwe     [2];
    logic [DW-1:0] raddr   [2];
    logic [DW-1:0] rwd     [2];
    logic          ready   [2];
    logic          resp_v  [2];
    logic [DW-1:0] rdata_o [2];
    logic          busy_s  [2];
    logic          ren     [2];
    logic          wen     [2];
    logic [DW-1:0] maddr   [2];
    logic [DW-1:0] mwd     [2];
    logic [DW-1:0] mrd     [2];

    logic [DW-1:0] p0;
    logic [DW-1:0] p1 [4];
    exp_t          q0 [$];
    exp_t          q1 [$];
    logic [DW-1:0] last [2];
    int            cyc;
    int            vecs;
    int            errs;

    mem_access_unit #(.READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(ready[0]), .req_we(rwe[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .resp_valid(resp_v[0]), .resp_rdata(rdata_o[0]), .busy(busy_s[0]),
        .mc_ren(ren[0]), .mc_wen(wen[0]), .mc_address(maddr[0]),
        .mc_wdata(mwd[0]), .mc_rdata(mrd[0])
    );

    mem_access_unit #(.READ_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(ready[1]), .req_we(rwe[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .resp_valid(resp_v[1]), .resp_rdata(rdata_o[1]), .busy(busy_s[1]),
        .mc_ren(ren[1]), .mc_wen(wen[1]), .mc_address(maddr[1]),
        .mc_wdata(mwd[1]), .mc_rdata(mrd[1])
    );

    function automatic logic [DW-1:0] memf(input logic [DW-1:0] a);
        case (a)
            DW'(32'h10): memf = DW'(32'hA5A5);
            DW'(32'h20): memf = DW'(32'h1234);
            default:     memf = a ^ DW'(32'h5A5A_0000);
        endcase
    endfunction

    function automatic int lat(input int d);
        lat = (d == 0) ? 1 : 4;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data is valid exactly READ_LATENCY cycles after mc_ren.
    always @(posedge clk) begin
        p0    <= ren[0] ? memf(maddr[0]) : GARB;
        p1[0] <= ren[1] ? memf(maddr[1]) : GARB;
        for (int i = 1; i < 4; i++) p1[i] <= p1[i-1];
    end
    assign mrd[0] = p0;
    assign mrd[1] = p1[3];

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input int d, input exp_t e);
        chk($sformatf("resp_cycle[%0d]", d), DW'(cyc), DW'(e.cyc));
        chk($sformatf("resp_rdata[%0d]", d), rdata_o[d], e.data);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_v[0]) begin
                if (q0.size() == 0) chk("spurious_resp[0]", DW'(q0.size()), DW'(1));
                else chk_resp(0, q0.pop_front());
            end
            if (resp_v[1]) begin
                if (q1.size() == 0) chk("spurious_resp[1]", DW'(q1.size()), DW'(1));
                else chk_resp(1, q1.pop_front());
            end
            chk("ren_wen_excl[0]", DW'(ren[0] && wen[0]), '0);
            chk("ren_wen_excl[1]", DW'(ren[1] && wen[1]), '0);
        end
    end

    // Starts at a negedge; returns the accept cycle in t (-1 on timeout).
    task automatic issue(input int d, input bit we, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input bit hold,
                         output int t);
        int   n;
        exp_t e;
        rv[d]    = 1'b1;
        rwe[d]   = we;
        raddr[d] = a;
        rwd[d]   = wd;
        n        = 0;
        while (!ready[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_timeout[%0d]", d), DW'(n < 60), DW'(1));
        if (n >= 60) begin
            rv[d] = 1'b0;
            t     = -1;
            return;
        end
        t = cyc;
        if (!we) last[d] = memf(a);
        e.cyc  = we ? t + WR_LAT : t + 2 + lat(d);
        e.data = last[d];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        chk($sformatf("mc_ren[%0d]", d), DW'(ren[d]), DW'(!we));
        chk($sformatf("mc_wen[%0d]", d), DW'(wen[d]), DW'(we));
        chk($sformatf("mc_address[%0d]", d), maddr[d], a);
        if (we) chk($sformatf("mc_wdata[%0d]", d), mwd[d], wd);
        if (!hold) rv[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy_s[0] || busy_s[1])
               && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", DW'(n < 50), DW'(1));
        @(negedge clk);
    endtask

    initial begin
        int t0, t1, t2, t3;
        cyc  = 0;
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d]    = 1'b1;
            rwe[d]   = 1'b0;
            raddr[d] = '0;
            rwd[d]   = '0;
            last[d]  = '0;
        end

        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_ready[%0d]", d), DW'(ready[d]), '0);
                chk($sformatf("rst_ren[%0d]", d), DW'(ren[d]), '0);
                chk($sformatf("rst_wen[%0d]", d), DW'(wen[d]), '0);
                chk($sformatf("rst_resp_v[%0d]", d), DW'(resp_v[d]), '0);
                chk($sformatf("rst_rdata[%0d]", d), rdata_o[d], '0);
            end
        end
        rst   = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready[0]", DW'(ready[0]), DW'(1));
        chk("post_rst_ready[1]", DW'(ready[1]), DW'(1));

        issue(0, 1'b0, DW'(32'h10), '0, 1'b0, t0);
        drain();
        issue(1, 1'b0, DW'(32'h20), '0, 1'b0, t0);
        drain();
        issue(1, 1'b1, DW'(32'h30), DW'(32'hBEEF), 1'b0, t0);
        drain();
        chk("rdata_held[1]", rdata_o[1], DW'(32'h1234));
        issue(0, 1'b1, DW'(32'h30), DW'(32'hBEEF), 1'b0, t0);
        drain();

        issue(0, 1'b1, DW'(32'h70), DW'(32'h1111), 1'b1, t0);
        issue(0, 1'b1, DW'(32'h74), DW'(32'h2222), 1'b1, t1);
        issue(0, 1'b1, DW'(32'h78), DW'(32'h3333), 1'b1, t2);
        issue(0, 1'b1, DW'(32'h7C), DW'(32'h4444), 1'b0, t3);
        chk("store_spacing_1", DW'(t1 - t0), DW'(WR_LAT));
        chk("store_spacing_2", DW'(t2 - t1), DW'(WR_LAT));
        chk("store_spacing_3", DW'(t3 - t2), DW'(WR_LAT));
        drain();

        issue(1, 1'b1, DW'(32'h40), DW'(32'h55), 1'b1, t0);
        issue(1, 1'b0, DW'(32'h44), '0, 1'b1, t1);
        issue(1, 1'b0, DW'(32'h48), '0, 1'b0, t2);
        chk("st_ld_b2b", DW'(t1 - t0), DW'(WR_LAT));
        chk("ld_held_off", DW'(t2 - t1), DW'(2 + 4));
        drain();

        issue(1, 1'b0, DW'(32'h50), '0, 1'b0, t0);
        repeat (2) @(negedge clk);
        chk("mid_busy[1]", DW'(busy_s[1]), DW'(1));
        rst = 1'b1;
        q0.delete();
        q1.delete();
        last[0] = '0;
        last[1] = '0;
        @(negedge clk);
        chk("mid_rst_resp_v[1]", DW'(resp_v[1]), '0);
        chk("mid_rst_ren[1]", DW'(ren[1]), '0);
        chk("mid_rst_busy[1]", DW'(busy_s[1]), '0);
        chk("mid_rst_rdata[1]", rdata_o[1], '0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(1, 1'b0, DW'(32'h60), '0, 1'b0, t0);
        drain();
        chk("final_rdata[1]", rdata_o[1], memf(DW'(32'h60)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
